// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-zero constant and the operand match helper.
package hazard_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_BR_HOLD  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    // Register x is read by the ID instruction; r0 never creates a dependence.
    function automatic logic reg_match(
        input logic [REG_W-1:0] x,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return (x != REG_ZERO) && ((x == rs) || ((x == rt) && uses_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control.sv
// Stall / flush / freeze control for a 5-stage pipeline with branches
// resolved in ID and a data memory that can assert a wait request.
module hazard_control
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             ID_Uses_Rt,
    input  logic             ID_Is_Branch,
    input  logic             Branch_Taken,
    input  logic             Jump,
    input  logic [4:0]       ID_EX_dest,
    input  logic             ID_EX_Reg_Write,
    input  logic             ID_EX_Mem_Read,
    input  logic [4:0]       EX_MEM_dest,
    input  logic             EX_MEM_Mem_Read,
    input  logic             Mem_Busy,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Pipe_Freeze,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    state_e state_q, state_d;
    state_e ret_q, ret_d;
    state_e eff_state;

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic br_alu;
    logic br_load_ex;
    logic br_load_mem;
    logic hz;

    always_comb begin
        ex_match    = reg_match(ID_EX_dest, rs, rt, ID_Uses_Rt);
        mem_match   = reg_match(EX_MEM_dest, rs, rt, ID_Uses_Rt);
        load_use    = ID_EX_Mem_Read && ex_match;
        br_alu      = ID_Is_Branch && ID_EX_Reg_Write && !ID_EX_Mem_Read && ex_match;
        br_load_ex  = ID_Is_Branch && ID_EX_Mem_Read && ex_match;
        br_load_mem = ID_Is_Branch && EX_MEM_Mem_Read && mem_match;
        hz          = load_use || br_alu || br_load_ex || br_load_mem;
    end

    // Leaving a memory wait, act as whichever state the wait interrupted.
    assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;

        if (!rst_n) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (Mem_Busy) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Freeze = 1'b1;
            state_d     = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                ret_d = state_q;
            end
        end else begin
            case (eff_state)
                ST_BR_HOLD: begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    state_d      = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    if (hz) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        if (br_load_ex) begin
                            state_d = ST_BR_HOLD;
                        end
                    end else if (Jump || (ID_Is_Branch && Branch_Taken)) begin
                        IF_ID_Flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!PC_Write),
        .count (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (IF_ID_Flush),
        .count (Flush_Count)
    );

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-002 SHALL have ports, one per line (name direction width meaning):
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- rs  input  5  IF/ID source register 1
- rt  input  5  IF/ID source register 2
- ID_Uses_Rt  input  1  ID instruction reads rt
- ID_Is_Branch  input  1  ID instruction is beq/bne (compared in ID)
- Branch_Taken  input  1  ID branch resolved taken
- Jump  input  1  ID instruction is j/jal
- ID_EX_dest  input  5  destination register in EX
- ID_EX_Reg_Write  input  1  EX instruction writes a register
- ID_EX_Mem_Read  input  1  EX instruction is a load
- EX_MEM_dest  input  5  destination register in MEM
- EX_MEM_Mem_Read  input  1  MEM instruction is a load
- Mem_Busy  input  1  data memory wait request
- PC_Write  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register enable
- ID_EX_Bubble  output  1  zero ID/EX control fields
- IF_ID_Flush  output  1  squash the fetched instruction
- Pipe_Freeze  output  1  hold ID/EX, EX/MEM, MEM/WB
- Stall_Count  output  CNT_W  stall cycles, saturating
- Flush_Count  output  CNT_W  flushes, saturating

Function
REQ-003 SHALL define the match terms mA = (x==rs) and mB = (x==rt && ID_Uses_Rt), with x!=0 required for every match.
REQ-004 SHALL define hazard terms:
- load_use: ID_EX_Mem_Read and ID_EX_dest matches.
- br_alu: ID_Is_Branch, ID_EX_Reg_Write, ID_EX_Mem_Read=0, and ID_EX_dest matches.
- br_load_ex: ID_Is_Branch, ID_EX_Mem_Read, and ID_EX_dest matches.
- br_load_mem: ID_Is_Branch, EX_MEM_Mem_Read, and EX_MEM_dest matches.
REQ-005 SHALL implement FSM states RUN, BR_HOLD, MEM_WAIT. Encoding is held in the package.
REQ-006 In RUN with Mem_Busy=0: hz = load_use|br_alu|br_load_ex|br_load_mem. If hz: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, same cycle (Mealy). Next state is BR_HOLD if br_load_ex, else RUN.
REQ-007 BR_HOLD SHALL force the stall outputs of REQ-006 for exactly one cycle, independent of hazard inputs, then return to RUN. A load-to-branch dependence in EX therefore costs exactly 2 stall cycles.
REQ-008 IF_ID_Flush SHALL be 1 only in RUN, with hz=0, Mem_Busy=0, and (Jump or (ID_Is_Branch and Branch_Taken)). It is suppressed during any stall.
REQ-009 Mem_Busy=1 in any state SHALL give:
- PC_Write=0, IF_ID_Write=0, Pipe_Freeze=1, ID_EX_Bubble=0, IF_ID_Flush=0.
- Next state MEM_WAIT.
- The interrupted state (RUN or BR_HOLD) is saved in a return register.
REQ-010 MEM_WAIT with Mem_Busy=0 SHALL behave as the saved state in that same cycle and transition exactly as that state would. A pending BR_HOLD cycle is never lost.
REQ-011 With no stall, freeze, or reset active: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, Pipe_Freeze=0.
REQ-012 Stall_Count SHALL increment by 1 on each rising edge where PC_Write=0 and rst_n=1. Flush_Count SHALL increment on each edge where IF_ID_Flush=1. Both saturate at all-ones with no wrap.

Reset
REQ-013 rst_n=0 SHALL asynchronously set state=RUN, saved state=RUN, Stall_Count=0, Flush_Count=0.
REQ-014 While rst_n=0: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0, Pipe_Freeze=0. Reset mid-stall or mid-wait discards the pending state.

Structure
REQ-015 Shared package hazard_pkg SHALL hold the FSM state encoding (2 bits) and the register-zero constant.
REQ-016 The saturating counter SHALL be one sub-module, sat_counter (width parameter, enable), instantiated twice.

Verification
REQ-017 Load-use: ID_EX_Mem_Read=1, ID_EX_dest=5, rs=5 -> one cycle PC_Write=0 and ID_EX_Bubble=1, Stall_Count 0->1.
REQ-018 Load-branch: ID_Is_Branch=1, rs=8, load with dest 8 in EX then MEM -> exactly 2 stall cycles, state RUN->BR_HOLD->RUN, Stall_Count=2.
REQ-019 Taken branch with no hazard: Branch_Taken=1 -> IF_ID_Flush=1 for one cycle, Flush_Count=1. Same input during a load-use stall -> IF_ID_Flush=0.
REQ-020 Zero register: ID_EX_Mem_Read=1, ID_EX_dest=0, rs=0 -> no stall. ID_Uses_Rt=0 with rt matching -> no stall.
REQ-021 Mem_Busy high for 3 cycles during BR_HOLD -> Pipe_Freeze=1 for 3 cycles, then one BR_HOLD stall cycle, then RUN.
REQ-022 Counter preloaded near all-ones (CNT_W=4, 15 stalls, then 2 more) -> Stall_Count holds 15. rst_n pulsed low mid-stall -> outputs per REQ-014 immediately, counts 0.
